// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
//   Bundles the signals around ram_fifo_ctrl: the producer/consumer handshake
//   and the single-port ram bus.
//   Optional: FIFO_LEVEL_EN adds level, almost_full and almost_empty.
//
//   Ports of the modports:
//     slave  : the controller (drives ready/valid/flags and ram_*, reads ram_out)
//     master : the producer/consumer plus ram side (drives push/pop/data and ram_out)
//
//   Handshake: a push transfers on a cycle where push && push_ready, a pop on
//   a cycle where pop && pop_ready. pop_valid is a one-cycle strobe one clock
//   after each transferred pop; pop_data is meaningful only while pop_valid=1.
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8
);
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] ram_in;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_out;
`ifdef FIFO_LEVEL_EN
  logic [ADDR_W:0]   level;
  logic              almost_full;
  logic              almost_empty;
`endif

  modport slave (
    input  push, push_data, pop, ram_out,
    output push_ready, pop_ready, pop_data, pop_valid, full, empty,
           ram_in, ram_addr, ram_en, ram_we
`ifdef FIFO_LEVEL_EN
    , output level, almost_full, almost_empty
`endif
  );

  modport master (
    output push, push_data, pop, ram_out,
    input  push_ready, pop_ready, pop_data, pop_valid, full, empty,
           ram_in, ram_addr, ram_en, ram_we
`ifdef FIFO_LEVEL_EN
    , input level, almost_full, almost_empty
`endif
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   Turns a single-port synchronous ram (one access per clock, read data one
//   clock after an en=1/we=0 access) into a FIFO using wrapping read/write
//   pointers and an occupancy counter.
//
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous active-low reset
//     bus  : ram_fifo_ctrl_if.slave (push/pop handshake, flags, ram bus)
//
//   Optional macro FIFO_LEVEL_EN: adds bus.level (= count) and registered
//   bus.almost_full (count >= AF_LEVEL) / bus.almost_empty (count <= AE_LEVEL).
//
//   The ram has one port, so a pop and a push can't both be served in one
//   cycle: pop wins and push_ready drops combinationally while a pop is
//   being accepted.
module ram_fifo_ctrl #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = 240,
  parameter int AE_LEVEL = 16
) (
  input logic           clk,
  input logic           rst,
  ram_fifo_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // Pointer wrap relies on natural ADDR_W-bit overflow, so DEPTH must be 2**ADDR_W.
  if (DEPTH != (1 << ADDR_W) || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_param_check
    $error("ram_fifo_ctrl: inconsistent DEPTH/ADDR_W/AF_LEVEL/AE_LEVEL");
  end

  logic [ADDR_W:0]   count, count_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr_q, addr_w;
  logic [DATA_W-1:0] in_q, in_w;
  logic [DATA_W-1:0] data_q;
  logic              pop_valid_q;
  logic              en_w, we_w;
  logic              empty_w, full_w;
  logic              pop_acc, push_acc;

  // Flags come from the counter, not pointer equality, so full and empty
  // are unambiguous when rd_ptr == wr_ptr.
  assign empty_w  = (count == '0);
  assign full_w   = (count == FULL_CNT);
  assign pop_acc  = bus.pop && !empty_w;
  assign push_acc = bus.push && !full_w && !pop_acc;

  always_comb begin
    count_nxt = count;
    if (pop_acc)       count_nxt = count - (ADDR_W+1)'(1);
    else if (push_acc) count_nxt = count + (ADDR_W+1)'(1);
  end

  // Ram drive is combinational so the ram samples this cycle's request at
  // the same edge that advances the pointers. Idle cycles replay the last
  // address/data so the bus doesn't toggle needlessly.
  always_comb begin
    en_w   = 1'b0;
    we_w   = 1'b0;
    addr_w = addr_q;
    in_w   = in_q;
    if (pop_acc) begin
      en_w   = 1'b1;
      addr_w = rd_ptr;
    end else if (push_acc) begin
      en_w   = 1'b1;
      we_w   = 1'b1;
      addr_w = wr_ptr;
      in_w   = bus.push_data;
    end
  end

  // Gated by rst so the ram sees an idle, zeroed bus for the whole reset,
  // even while push is held high.
  assign bus.ram_en   = rst & en_w;
  assign bus.ram_we   = rst & we_w;
  assign bus.ram_addr = rst ? addr_w : '0;
  assign bus.ram_in   = rst ? in_w   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      addr_q      <= '0;
      in_q        <= '0;
      pop_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      count       <= count_nxt;
      addr_q      <= addr_w;
      in_q        <= in_w;
      pop_valid_q <= pop_acc;
      if (pop_acc)     rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push_acc)    wr_ptr <= wr_ptr + ADDR_W'(1);
      // Keep the delivered word so pop_data holds after the strobe.
      if (pop_valid_q) data_q <= bus.ram_out;
    end
  end

  // Ram read data is live in the strobe cycle; afterwards show the held copy.
  assign bus.pop_data   = pop_valid_q ? bus.ram_out : data_q;
  assign bus.pop_valid  = pop_valid_q;
  assign bus.pop_ready  = !empty_w;
  assign bus.push_ready = !full_w && !pop_acc;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;

`ifdef FIFO_LEVEL_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT = (ADDR_W+1)'(AE_LEVEL);

  logic af_q, ae_q;

  // Registered from count_nxt so the flags change on the same edge as count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_nxt >= AF_CNT);
      ae_q <= (count_nxt <= AE_CNT);
    end
  end

  assign bus.level        = count;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int AF     = 240;
  localparam int AE     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_fifo_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- ram block ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_in;
      else            bus.ram_out       <= mem[bus.ram_addr];
    end
  end

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The FIFO is an ordered queue of words; pointers are plain integers mod DEPTH.
  logic [DATA_W-1:0] exp_q[$];
  int                m_wp = 0;
  int                m_rp = 0;
  bit                m_pv = 0;
  logic [DATA_W-1:0] m_pd = '0;
  bit                m_pd_known = 0;
  int                m_last_addr = 0;
  logic [DATA_W-1:0] m_last_in = '0;

  function automatic bit m_pop_acc();
    return bus.pop && (exp_q.size() != 0);
  endfunction

  function automatic bit m_push_acc();
    return bus.push && (exp_q.size() != DEPTH) && !m_pop_acc();
  endfunction

  always @(posedge clk or negedge rst) begin : model_upd
    bit pa, wa;
    if (!rst) begin
      exp_q.delete();
      m_wp = 0; m_rp = 0; m_pv = 0; m_pd_known = 0;
      m_last_addr = 0; m_last_in = '0;
    end else begin
      pa = m_pop_acc();
      wa = m_push_acc();
      m_pv = pa;
      if (pa) begin
        m_pd = exp_q.pop_front();
        m_pd_known = 1;
        m_last_addr = m_rp;
        m_rp = (m_rp + 1) % DEPTH;
      end
      if (wa) begin
        exp_q.push_back(bus.push_data);
        m_last_addr = m_wp;
        m_last_in = bus.push_data;
        m_wp = (m_wp + 1) % DEPTH;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    bit pa, wa;
    int e_addr;
    if (!rst) begin
      chk("rst_ram_en", bus.ram_en, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_ram_in", bus.ram_in, 0);
      chk("rst_pop_valid", bus.pop_valid, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
`ifdef FIFO_LEVEL_EN
      chk("rst_level", bus.level, 0);
      chk("rst_af", bus.almost_full, 0);
      chk("rst_ae", bus.almost_empty, 1);
`endif
    end else begin
      pa = m_pop_acc();
      wa = m_push_acc();
      e_addr = pa ? m_rp : (wa ? m_wp : m_last_addr);
      chk("empty", bus.empty, exp_q.size() == 0);
      chk("full", bus.full, exp_q.size() == DEPTH);
      chk("pop_ready", bus.pop_ready, exp_q.size() != 0);
      chk("push_ready", bus.push_ready, (exp_q.size() != DEPTH) && !pa);
      chk("ram_en", bus.ram_en, pa || wa);
      chk("ram_we", bus.ram_we, wa);
      chk("ram_addr", bus.ram_addr, e_addr);
      if (!pa) chk("ram_in", bus.ram_in, wa ? bus.push_data : m_last_in);
      chk("pop_valid", bus.pop_valid, m_pv);
      if (m_pv || m_pd_known) chk("pop_data", bus.pop_data, m_pd);
`ifdef FIFO_LEVEL_EN
      chk("level", bus.level, exp_q.size());
      chk("almost_full", bus.almost_full, exp_q.size() >= AF);
      chk("almost_empty", bus.almost_empty, exp_q.size() <= AE);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit p, input logic [DATA_W-1:0] d, input bit q);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] v4 [4];
  int pp;

  initial begin
    v4 = '{10'd5, 10'd60, 10'd100, 10'd420};
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_empty", bus.empty, 1);
    chk("init_full", bus.full, 0);
    chk("init_pop_valid", bus.pop_valid, 0);
    chk("init_ram_en", bus.ram_en, 0);
    rst = 1'b1;

    // Four consecutive pushes.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v4[i], 1'b0);
      chk("p1_addr", bus.ram_addr, i);
      chk("p1_we", bus.ram_we, 1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    chk("p1_empty", bus.empty, 0);
    chk("p1_model_cnt", exp_q.size(), 4);
`ifdef FIFO_LEVEL_EN
    chk("p1_level", bus.level, 4);
`endif

    // Four consecutive pops; data arrives one cycle behind.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      chk("p2_addr", bus.ram_addr, i);
      chk("p2_we", bus.ram_we, 0);
      if (i > 0) begin
        chk("p2_pv", bus.pop_valid, 1);
        chk("p2_data", bus.pop_data, v4[i-1]);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    chk("p2_pv_last", bus.pop_valid, 1);
    chk("p2_data_last", bus.pop_data, 420);
    tick();
    chk("p2_empty", bus.empty, 1);
    chk("p2_pv_off", bus.pop_valid, 0);

    // Fill from a clean reset, overflow attempt, then wrap.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DATA_W'(i), 1'b0);
      tick();
    end
    drive(1'b1, 10'd999, 1'b0);
    chk("p3_full", bus.full, 1);
    chk("p3_push_ready", bus.push_ready, 0);
    chk("p3_ram_en", bus.ram_en, 0);
    chk("p3_model_cnt", exp_q.size(), 256);
    tick();
    drive(1'b0, '0, 1'b0);
    chk("p3_still_full", bus.full, 1);
`ifdef FIFO_LEVEL_EN
    chk("p3_level", bus.level, 256);
    chk("p3_af", bus.almost_full, 1);
`endif
    drive(1'b0, '0, 1'b1);
    chk("p4_pop_addr", bus.ram_addr, 0);
    tick();
    drive(1'b1, 10'd777, 1'b0);
    chk("p4_pv", bus.pop_valid, 1);
    chk("p4_data0", bus.pop_data, 0);
    chk("p4_wrap_addr", bus.ram_addr, 0);
    chk("p4_wrap_we", bus.ram_we, 1);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      if (i > 0) chk("p4_data", bus.pop_data, i);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    chk("p4_pv_777", bus.pop_valid, 1);
    chk("p4_data_777", bus.pop_data, 777);
    tick();
    chk("p4_empty", bus.empty, 1);

    // Push and pop held together from count=3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_W'(11 + i), 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 10'd42, 1'b1);
      chk("p5_push_ready", bus.push_ready, 0);
      chk("p5_pop_ready", bus.pop_ready, 1);
      chk("p5_we", bus.ram_we, 0);
      chk("p5_addr", bus.ram_addr, 1 + k);
      tick();
    end
    drive(1'b1, 10'd42, 1'b1);
    chk("p5_empty_pop_ready", bus.pop_ready, 0);
    chk("p5_empty_push_ready", bus.push_ready, 1);
    chk("p5_empty_we", bus.ram_we, 1);
    chk("p5_empty_addr", bus.ram_addr, 4);
    chk("p5_empty_in", bus.ram_in, 42);
    chk("p5_old_pv", bus.pop_valid, 1);
    chk("p5_old_data", bus.pop_data, 13);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    chk("p5_data42", bus.pop_data, 42);
    tick();

    // Randomized traffic with push-heavy and pop-heavy phases.
    for (int blk = 0; blk < 5; blk++) begin
      case (blk)
        0: pp = 90;
        1: pp = 10;
        2: pp = 90;
        3: pp = 50;
        default: pp = 10;
      endcase
      for (int c = 0; c < 400; c++) begin
        drive($urandom_range(99, 0) < pp, DATA_W'($urandom_range(1023, 0)),
              $urandom_range(99, 0) < (100 - pp));
        tick();
      end
    end
    for (int c = 0; c < 300; c++) begin
      drive(1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();

    // Reset between the pop edge and its pop_valid cycle.
    drive(1'b1, 10'd3, 1'b0);
    tick();
    drive(1'b1, 10'd4, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    rst = 1'b0;
    bus.pop = 1'b0;
    #1;
    chk("p7_pv", bus.pop_valid, 0);
    chk("p7_empty", bus.empty, 1);
    chk("p7_ram_en", bus.ram_en, 0);
`ifdef FIFO_LEVEL_EN
    chk("p7_level", bus.level, 0);
    chk("p7_ae", bus.almost_empty, 1);
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("p7_pv_after", bus.pop_valid, 0);
    chk("p7_empty_after", bus.empty, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
